// File: rtl/median_pkg.sv
// median_pkg
// Shared constants for the 9x9 median datapath.
//   KSIZE       - window side length (9)
//   KAREA       - samples per window (81)
//   PIXEL_W_DEF - default pixel width in bits
//   idx()       - maps a window (row, col) to its 1-based S-number, row-major
package median_pkg;

    localparam int KSIZE       = 9;
    localparam int KAREA       = KSIZE * KSIZE;
    localparam int PIXEL_W_DEF = 8;

    function automatic int idx(input int row, input int col);
        return row * KSIZE + col + 1;
    endfunction

endpackage

// File: rtl/median_9x9_window_gen_if.sv
// median_9x9_window_gen_if
// Pixel-in / window-out bundle of the window generator.
//   done_i       - pixel valid
//   data_i       - pixel value, raster order
//   window_o     - flattened 9x9 window, S(k) = window_o[k*PIXEL_W-1 -: PIXEL_W]
//   done_o       - window valid strobe
//   frame_done_o - pulse with the last window of a frame
// Modports: slave = window generator, master = pixel source / window sink.
interface median_9x9_window_gen_if
    import median_pkg::*;
#(
    parameter int PIXEL_W = PIXEL_W_DEF
);

    logic                       done_i;
    logic [PIXEL_W-1:0]         data_i;
    logic [KAREA*PIXEL_W-1:0]   window_o;
    logic                       done_o;
    logic                       frame_done_o;

    modport slave (
        input  done_i,
        input  data_i,
        output window_o,
        output done_o,
        output frame_done_o
    );

    modport master (
        output done_i,
        output data_i,
        input  window_o,
        input  done_o,
        input  frame_done_o
    );

endinterface

// File: rtl/median_line_buffer.sv
// median_line_buffer
// WIDTH-deep shift buffer built as a circular RAM. q is the entry written
// WIDTH enables ago; it is read at the pointer before that slot is overwritten.
//   clk  - clock
//   rst  - synchronous active-high reset (pointer only, storage not cleared)
//   en   - shift enable
//   data - value shifted in
//   q    - value shifted out (oldest entry)
module median_line_buffer
    import median_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int PIXEL_W = PIXEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PIXEL_W-1:0] data,
    output logic [PIXEL_W-1:0] q
);

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PIXEL_W-1:0] mem [WIDTH];
    logic [AW-1:0]      ptr;

    assign q = mem[ptr];

    always_ff @(posedge clk) begin
        if (en && !rst) begin
            mem[ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(WIDTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/median_9x9_window_gen.sv
// median_9x9_window_gen
// Builds every full 9x9 neighbourhood of a raster pixel stream using 8
// cascaded line buffers and a 9x9 register window.
//   clk - clock
//   rst - synchronous active-high reset
//   bus - slave side of median_9x9_window_gen_if (done_i/data_i in,
//         window_o/done_o/frame_done_o out, all outputs registered)
module median_9x9_window_gen
    import median_pkg::*;
#(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int PIXEL_W = PIXEL_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    median_9x9_window_gen_if.slave   bus
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int NLB = KSIZE - 1;

    logic               accept;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               col_last;
    logic               row_last;
    logic               win_full;

    logic [PIXEL_W-1:0] lb_d    [NLB];
    logic [PIXEL_W-1:0] lb_q    [NLB];
    logic [PIXEL_W-1:0] new_col [KSIZE];
    logic [PIXEL_W-1:0] win     [KSIZE][KSIZE];

    assign accept   = bus.done_i && !rst;
    assign col_last = (col == CW'(WIDTH - 1));
    assign row_last = (row == RW'(HEIGHT - 1));
    assign win_full = (col >= CW'(KSIZE - 1)) && (row >= RW'(KSIZE - 1));

    // Cascade: LB0 takes the incoming pixel, LBk takes LB(k-1)'s output.
    always_comb begin
        lb_d[0] = bus.data_i;
        for (int unsigned k = 1; k < NLB; k++) begin
            lb_d[k] = lb_q[k-1];
        end
    end

    for (genvar k = 0; k < NLB; k++) begin : g_lb
        median_line_buffer #(
            .WIDTH   (WIDTH),
            .PIXEL_W (PIXEL_W)
        ) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (accept),
            .data (lb_d[k]),
            .q    (lb_q[k])
        );
    end

    // Rightmost column, top to bottom: oldest row (LB7) down to the live pixel.
    always_comb begin
        new_col[KSIZE-1] = bus.data_i;
        for (int unsigned i = 0; i < NLB; i++) begin
            new_col[i] = lb_q[NLB-1-i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col              <= '0;
            row              <= '0;
            win              <= '{default: '0};
            bus.done_o       <= 1'b0;
            bus.frame_done_o <= 1'b0;
        end else begin
            bus.done_o       <= accept && win_full;
            bus.frame_done_o <= accept && col_last && row_last;
            if (accept) begin
                for (int unsigned i = 0; i < KSIZE; i++) begin
                    for (int unsigned j = 0; j < KSIZE - 1; j++) begin
                        win[i][j] <= win[i][j+1];
                    end
                    win[i][KSIZE-1] <= new_col[i];
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.window_o = '0;
        for (int unsigned i = 0; i < KSIZE; i++) begin
            for (int unsigned j = 0; j < KSIZE; j++) begin
                bus.window_o[(idx(i, j) - 1) * PIXEL_W +: PIXEL_W] = win[i][j];
            end
        end
    end

endmodule

// File: tb/tb_median_9x9_window_gen.sv
// tb_median_9x9_window_gen
// Directed bench for median_9x9_window_gen on a 16x16 frame of 8-bit pixels.
// Pixel p of a frame (p = 16r + c) carries (p + off) & 0xFF, so every expected
// window sample is derived directly from its (row, col) position.
module tb_median_9x9_window_gen;
    import median_pkg::*;

    localparam int W    = 16;
    localparam int H    = 16;
    localparam int PW   = 8;
    localparam int WINW = KAREA * PW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    median_9x9_window_gen_if #(.PIXEL_W(PW)) bus ();

    median_9x9_window_gen #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .PIXEL_W (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int pulses;
    int accepted;
    int first_at;
    logic [WINW-1:0] prev_win;
    logic [WINW-1:0] first_win;

    task automatic check(input string tag, input logic [WINW-1:0] obs, input logic [WINW-1:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [PW-1:0] samp(input logic [WINW-1:0] w, input int k);
        return w[k*PW-1 -: PW];
    endfunction

    // Window for the pixel accepted at (r, c): rows r-8..r, cols c-8..c.
    function automatic logic [WINW-1:0] exp_win(input int r, input int c, input int off);
        logic [WINW-1:0] w;
        w = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                w[(idx(i, j) - 1) * PW +: PW] = PW'(((r - 8 + i) * W + (c - 8 + j) + off) & 255);
            end
        end
        return w;
    endfunction

    task automatic step(input logic v, input logic [PW-1:0] d, input int r, input int c,
                        input int off, input string tag);
        logic exp_done;
        logic exp_frame;
        @(negedge clk);
        bus.done_i = v;
        bus.data_i = d;
        @(posedge clk);
        #1;
        if (v) accepted++;
        if (bus.done_o === 1'b1) begin
            pulses++;
            if (first_at < 0) begin
                first_at  = accepted;
                first_win = bus.window_o;
            end
        end
        if (v) begin
            exp_done  = (r >= 8) && (c >= 8);
            exp_frame = (r == H - 1) && (c == W - 1);
            check({tag, " done_o"}, WINW'(bus.done_o), WINW'(exp_done));
            check({tag, " frame_done_o"}, WINW'(bus.frame_done_o), WINW'(exp_frame));
            if (exp_done) check({tag, " window"}, bus.window_o, exp_win(r, c, off));
        end else begin
            check({tag, " gap done_o"}, WINW'(bus.done_o), '0);
            check({tag, " gap frame_done_o"}, WINW'(bus.frame_done_o), '0);
            check({tag, " gap window hold"}, bus.window_o, prev_win);
        end
        prev_win = bus.window_o;
    endtask

    task automatic run_frame(input int off, input bit gapped, input string tag, input int npix);
        pulses   = 0;
        accepted = 0;
        first_at = -1;
        for (int p = 0; p < npix; p++) begin
            step(1'b1, PW'((p + off) & 255), p / W, p % W, off, tag);
            if (gapped) step(1'b0, 8'hAA, p / W, p % W, off, tag);
        end
    endtask

    task automatic frame_summary(input string tag, input int off);
        check({tag, " pulse count"}, WINW'(pulses), WINW'(64));
        check({tag, " first pulse index"}, WINW'(first_at), WINW'(137));
        check({tag, " first S1"}, WINW'(samp(first_win, 1)), WINW'((0 + off) & 255));
        check({tag, " first S41"}, WINW'(samp(first_win, 41)), WINW'((68 + off) & 255));
        check({tag, " first S81"}, WINW'(samp(first_win, 81)), WINW'((136 + off) & 255));
        check({tag, " last S1"}, WINW'(samp(bus.window_o, 1)), WINW'((119 + off) & 255));
        check({tag, " last S81"}, WINW'(samp(bus.window_o, 81)), WINW'((255 + off) & 255));
    endtask

    initial begin
        // Reset held for two edges with a valid pixel presented.
        rst        = 1'b1;
        bus.done_i = 1'b1;
        bus.data_i = 8'hFF;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            check("reset done_o", WINW'(bus.done_o), '0);
            check("reset frame_done_o", WINW'(bus.frame_done_o), '0);
            check("reset window_o", bus.window_o, '0);
        end
        @(negedge clk);
        rst        = 1'b0;
        bus.done_i = 1'b0;
        prev_win   = bus.window_o;

        // Continuous ramp.
        run_frame(0, 1'b0, "cont", W * H);
        frame_summary("cont", 0);

        // Same frame with a bubble after every pixel.
        run_frame(0, 1'b1, "gap", W * H);
        frame_summary("gap", 0);

        // Back-to-back frames, the second offset by 0x10.
        run_frame(0, 1'b0, "b2b0", W * H);
        frame_summary("b2b0", 0);
        run_frame(16, 1'b0, "b2b1", W * H);
        frame_summary("b2b1", 16);
        check("b2b1 first S1 0x10", WINW'(samp(first_win, 1)), WINW'(8'h10));
        check("b2b1 first S81 0x98", WINW'(samp(first_win, 81)), WINW'(8'h98));

        // Reset after 100 pixels, then a fresh frame.
        run_frame(0, 1'b0, "pre", 100);
        @(negedge clk);
        rst        = 1'b1;
        bus.done_i = 1'b1;
        bus.data_i = 8'hFF;
        @(posedge clk);
        #1;
        check("mid reset done_o", WINW'(bus.done_o), '0);
        check("mid reset window_o", bus.window_o, '0);
        @(negedge clk);
        rst        = 1'b0;
        bus.done_i = 1'b0;
        prev_win   = bus.window_o;
        run_frame(0, 1'b0, "post", W * H);
        frame_summary("post", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
